// File: rtl/nes_joypad_pkg.sv
// Shared constants for the NES joypad hub: button bit positions, four-score signature, read index sizing.
// Pure definitions, no latency.
// No flow control.
package nes_joypad_pkg;

   localparam int C_BTN_A      = 0;
   localparam int C_BTN_B      = 1;
   localparam int C_BTN_SELECT = 2;
   localparam int C_BTN_START  = 3;
   localparam int C_BTN_UP     = 4;
   localparam int C_BTN_DOWN   = 5;
   localparam int C_BTN_LEFT   = 6;
   localparam int C_BTN_RIGHT  = 7;

   localparam int                 C_IDX_W   = 5;
   localparam logic [C_IDX_W-1:0] C_IDX_SAT = 5'd24;

   // Signature bytes shifted out at idx 16..23; bit n of the byte is idx 16+n.
   localparam logic [7:0] C_SIG_PORT0 = 8'h08;
   localparam logic [7:0] C_SIG_PORT1 = 8'h04;

   typedef logic [7:0] pad_t;

   function automatic pad_t apply_turbo(input pad_t pad, input logic [1:0] turbo, input logic phase);
      pad_t eff;
      eff = pad;
      if (turbo[0]) eff[C_BTN_A] = pad[C_BTN_A] & phase;
      if (turbo[1]) eff[C_BTN_B] = pad[C_BTN_B] & phase;
      return eff;
   endfunction

endpackage

// File: rtl/nes_joypad_hub_if.sv
// Joypad bus between the NES register side / controller sources (master) and the hub (slave).
// Plain wires, no latency.
// No flow control.
interface nes_joypad_hub_if #(
   parameter int C_players = 2
);
   logic                     joy_strobe;
   logic [1:0]               joy_clock;
   logic [1:0]               joy_data;
   logic [8*C_players-1:0]   btn_pad;
   logic [2*C_players-1:0]   btn_turbo;

   modport master (
      output joy_strobe, joy_clock, btn_pad, btn_turbo,
      input  joy_data
   );

   modport slave (
      input  joy_strobe, joy_clock, btn_pad, btn_turbo,
      output joy_data
   );
endinterface

// File: rtl/nes_joypad_hub_port.sv
// One NES controller port: read-clock edge detect, read index, snapshot latch, serial bit select.
// joy_data registered one clock after idx/snapshot update.
// No flow control; reads past the end saturate at idx 24.
module nes_joypad_port
   import nes_joypad_pkg::*;
#(
   parameter bit         C_fourscore = 1'b0,
   parameter logic [7:0] C_sig       = 8'h00
) (
   input  logic clock,
   input  logic R_reset,
   input  logic i_strobe,
   input  logic i_joy_clock,
   input  pad_t i_eff_lo,
   input  pad_t i_eff_hi,
   output logic o_data
);

   logic               r_prev;
   logic [C_IDX_W-1:0] r_idx;
   pad_t               r_snap_lo;
   pad_t               r_snap_hi;
   logic               r_data;
   logic               w_fall;
   logic               w_sel;

   assign w_fall = r_prev & ~i_joy_clock;

   // Strobe has priority over a coincident falling edge so the sequence always restarts at a.
   always_ff @(posedge clock) begin
      if (R_reset) begin
         r_prev    <= 1'b0;
         r_idx     <= '0;
         r_snap_lo <= '0;
         r_snap_hi <= '0;
         r_data    <= 1'b0;
      end else begin
         r_prev <= i_joy_clock;
         if (i_strobe) begin
            r_snap_lo <= i_eff_lo;
            r_snap_hi <= i_eff_hi;
            r_idx     <= '0;
         end else if (w_fall && (r_idx != C_IDX_SAT)) begin
            r_idx <= r_idx + 5'd1;
         end
         r_data <= w_sel;
      end
   end

   always_comb begin
      w_sel = 1'b1;
      if (r_idx < 5'd8) begin
         w_sel = r_snap_lo[r_idx[2:0]];
      end else if (C_fourscore) begin
         if (r_idx < 5'd16)
            w_sel = r_snap_hi[r_idx[2:0]];
         else if (r_idx < 5'd24)
            w_sel = C_sig[r_idx[2:0]];
      end
   end

   assign o_data = r_data;

endmodule

// File: rtl/nes_joypad_hub.sv
// NES joypad hub: autofire, per-player button merge, two serial controller ports (four-score via NES_FOURSCORE_EN).
// joy_data registered one clock after each port's idx/snapshot update.
// No flow control; NES reads are paced by joy_strobe/joy_clock only.
module nes_joypad_hub
   import nes_joypad_pkg::*;
#(
   parameter int C_players      = 2,
   parameter int C_autofire_div = 1073741
) (
   input  logic             clock,
   input  logic             R_reset,
   nes_joypad_hub_if.slave  joy_if
);

   localparam int C_AF_W = (C_autofire_div > 1) ? $clog2(C_autofire_div) : 1;
   localparam logic [C_AF_W-1:0] C_AF_LAST = C_AF_W'(C_autofire_div - 1);

`ifdef NES_FOURSCORE_EN
   localparam bit C_FOURSCORE = (C_players > 2);
`else
   localparam bit C_FOURSCORE = 1'b0;
`endif

   logic [C_AF_W-1:0] r_af_cnt;
   logic              r_af_phase;
   pad_t              w_eff [4];
   logic [1:0]        w_data;

   always_ff @(posedge clock) begin
      if (R_reset) begin
         r_af_cnt   <= '0;
         r_af_phase <= 1'b0;
      end else if (r_af_cnt == C_AF_LAST) begin
         r_af_cnt   <= '0;
         r_af_phase <= ~r_af_phase;
      end else begin
         r_af_cnt <= r_af_cnt + C_AF_W'(1);
      end
   end

   // Absent players read as all-released so unused ports and four-score slots shift zeros.
   for (genvar p = 0; p < 4; p++) begin : g_eff
      if (p < C_players) begin : g_live
         assign w_eff[p] = apply_turbo(joy_if.btn_pad[8*p +: 8], joy_if.btn_turbo[2*p +: 2], r_af_phase);
      end else begin : g_absent
         assign w_eff[p] = '0;
      end
   end

   for (genvar k = 0; k < 2; k++) begin : g_port
      nes_joypad_port #(
         .C_fourscore (C_FOURSCORE),
         .C_sig       ((k == 0) ? C_SIG_PORT0 : C_SIG_PORT1)
      ) u_port (
         .clock       (clock),
         .R_reset     (R_reset),
         .i_strobe    (joy_if.joy_strobe),
         .i_joy_clock (joy_if.joy_clock[k]),
         .i_eff_lo    (w_eff[k]),
         .i_eff_hi    (w_eff[k+2]),
         .o_data      (w_data[k])
      );
   end

   assign joy_if.joy_data = w_data;

endmodule

// File: tb/tb_nes_joypad_hub.sv
// Directed bench for nes_joypad_hub: a 4-player hub and a 1-player hub, both with a 4-cycle autofire phase.
module tb_nes_joypad_hub;

   logic clock   = 1'b0;
   logic R_reset = 1'b1;

   always #5 clock = ~clock;

   nes_joypad_hub_if #(.C_players(4)) ja();
   nes_joypad_hub_if #(.C_players(1)) jb();

   nes_joypad_hub #(.C_players(4), .C_autofire_div(4)) u_dut_a (
      .clock   (clock),
      .R_reset (R_reset),
      .joy_if  (ja.slave)
   );

   nes_joypad_hub #(.C_players(1), .C_autofire_div(4)) u_dut_b (
      .clock   (clock),
      .R_reset (R_reset),
      .joy_if  (jb.slave)
   );

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] pad_a [4];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic strobe(input int d);
      if (d == 0) ja.joy_strobe = 1'b1; else jb.joy_strobe = 1'b1;
      tick(2);
      if (d == 0) ja.joy_strobe = 1'b0; else jb.joy_strobe = 1'b0;
      tick(2);
   endtask

   // One read pulse; returns once the port's new bit is on joy_data.
   task automatic rd(input int d, input int k);
      if (d == 0) ja.joy_clock[k] = 1'b1; else jb.joy_clock[k] = 1'b1;
      tick(1);
      if (d == 0) ja.joy_clock[k] = 1'b0; else jb.joy_clock[k] = 1'b0;
      tick(2);
   endtask

   function automatic logic data_of(input int d, input int k);
      return (d == 0) ? ja.joy_data[k] : jb.joy_data[k];
   endfunction

   // Expected serial bit for the 4-player hub at read index idx.
   function automatic logic exp_a(input int k, input int idx);
`ifdef NES_FOURSCORE_EN
      if (idx < 8)  return pad_a[k][idx];
      if (idx < 16) return pad_a[k+2][idx-8];
      if (idx < 24) return (k == 0) ? (idx == 19) : (idx == 18);
      return 1'b1;
`else
      if (idx < 8) return pad_a[k][idx];
      return 1'b1;
`endif
   endfunction

   initial begin
      ja.joy_strobe = 1'b1;
      ja.joy_clock  = 2'b00;
      ja.btn_pad    = 32'h0000_0001;
      ja.btn_turbo  = 8'b0000_0001;
      jb.joy_strobe = 1'b0;
      jb.joy_clock  = 2'b00;
      jb.btn_pad    = 8'h00;
      jb.btn_turbo  = 2'b00;

      R_reset = 1'b1;
      tick(3);
      check_eq("rst_data_a", 32'(ja.joy_data), 32'd0);
      check_eq("rst_data_b", 32'(jb.joy_data), 32'd0);
      R_reset = 1'b0;

      // Strobe held with turbo a: joy_data follows af_phase two clocks late.
      for (int m = 1; m <= 17; m++) begin
         tick(1);
         if (m >= 2)
            check_eq($sformatf("af_m%0d", m), 32'(ja.joy_data[0]), 32'(((m - 2) / 4) % 2));
      end

      ja.btn_turbo = 8'h00;
      pad_a[0] = 8'hA5;
      pad_a[1] = 8'h3C;
      pad_a[2] = 8'h01;
      pad_a[3] = 8'h00;
      ja.btn_pad = {pad_a[3], pad_a[2], pad_a[1], pad_a[0]};
      strobe(0);
      for (int k = 0; k < 2; k++) begin
         for (int idx = 0; idx <= 26; idx++) begin
            check_eq($sformatf("a_p%0d_i%0d", k, idx), 32'(data_of(0, k)),
                     32'(exp_a(k, (idx > 24) ? 24 : idx)));
            rd(0, k);
         end
      end

      // Falling read clock coincident with strobe must not advance idx.
      ja.joy_clock[0] = 1'b1;
      tick(1);
      ja.joy_strobe   = 1'b1;
      ja.joy_clock[0] = 1'b0;
      tick(1);
      ja.joy_strobe = 1'b0;
      tick(2);
      check_eq("coinc_a", 32'(ja.joy_data[0]), 32'd1);
      rd(0, 0);
      check_eq("coinc_b", 32'(ja.joy_data[0]), 32'd0);
      rd(0, 0);
      check_eq("coinc_sel", 32'(ja.joy_data[0]), 32'd1);

      jb.btn_pad = 8'h81;
      strobe(1);
      for (int idx = 0; idx <= 10; idx++) begin
         check_eq($sformatf("b_p0_i%0d", idx), 32'(jb.joy_data[0]), 32'((idx == 0) || (idx >= 7)));
         rd(1, 0);
      end
      for (int idx = 0; idx <= 9; idx++) begin
         check_eq($sformatf("b_p1_i%0d", idx), 32'(jb.joy_data[1]), 32'(idx >= 8));
         rd(1, 1);
      end

      jb.btn_pad = 8'hFF;
      strobe(1);
      rd(1, 0);
      rd(1, 0);
      rd(1, 0);
      check_eq("pre_rst", 32'(jb.joy_data[0]), 32'd1);
      R_reset = 1'b1;
      tick(1);
      check_eq("mid_rst_data", 32'(jb.joy_data), 32'd0);
      check_eq("mid_rst_idx", 32'(u_dut_b.g_port[0].u_port.r_idx), 32'd0);
      R_reset = 1'b0;
      rd(1, 0);
      check_eq("post_rst_rd1", 32'(jb.joy_data[0]), 32'd0);
      rd(1, 0);
      check_eq("post_rst_rd2", 32'(jb.joy_data[0]), 32'd0);
      strobe(1);
      check_eq("post_rst_strobe", 32'(jb.joy_data[0]), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
